pot_smoother: RTL and testbench

- Sits between the SPI pot reader and the pot state register bank.
- Consumes the raw per-pot ADC sample stream (value, pot_index, value_valid).
- Applies a per-channel first-order IIR low-pass, then a hysteresis deadband.
- Forwards a sample to the state bank only when the smoothed value has meaningfully changed. This suppresses ADC jitter on the audio-parameter pots.

---
 rtl/pot_smoother_if.sv | 20 ++
 rtl/pot_smoother.sv | 63 ++++++
 tb/tb_pot_smoother.sv | 129 ++++++++++++
 3 files changed

// File: rtl/pot_smoother_if.sv
// pot_smoother_if: raw ADC sample stream in, smoothed sample stream and channel primed flags out.
interface pot_smoother_if #(parameter int NUM_POTS = 12);
    logic [9:0]          value;
    logic [3:0]          pot_index;
    logic                value_valid;
    logic [9:0]          out_value;
    logic [3:0]          out_index;
    logic                out_valid;
    logic [NUM_POTS-1:0] primed;

    modport master (
        output value, pot_index, value_valid,
        input  out_value, out_index, out_valid, primed
    );

    modport slave (
        input  value, pot_index, value_valid,
        output out_value, out_index, out_valid, primed
    );
endinterface

// File: rtl/pot_smoother.sv
// pot_smoother: per-channel IIR low-pass plus hysteresis deadband on pot ADC samples.
module pot_smoother #(
    parameter int NUM_POTS = 12,
    parameter int SHIFT    = 2,
    parameter int DEADBAND = 4
) (
    input logic           clk,
    input logic           rst_n,
    pot_smoother_if.slave bus
);
    localparam int AW = 10 + SHIFT;

    logic [AW-1:0]       acc [NUM_POTS];
    logic [9:0]          rep [NUM_POTS];
    logic [NUM_POTS-1:0] primed_q;
    logic                accept, hit, snap;
    logic [3:0]          sel;
    logic [AW-1:0]       acc_cur;
    logic [AW:0]         acc_n;
    logic [9:0]          rep_cur, f, emit_val;
    logic [10:0]         diff, mag;

    assign bus.primed = primed_q;

    always_comb begin
        accept   = bus.value_valid && ({1'b0, bus.pot_index} < 5'(NUM_POTS));
        sel      = accept ? bus.pot_index : 4'd0;
        acc_cur  = acc[sel];
        rep_cur  = rep[sel];
        acc_n    = {1'b0, acc_cur} - {1'b0, acc_cur >> SHIFT} + (AW+1)'(bus.value);
        f        = 10'(acc_n[AW-1:0] >> SHIFT);
        diff     = {1'b0, f} - {1'b0, rep_cur};
        mag      = diff[10] ? -diff : diff;
        // endpoint snap keeps 0 and full scale reachable inside the deadband
        snap     = (f == 10'd0 && rep_cur != 10'd0) || (f == 10'd1023 && rep_cur != 10'd1023);
        hit      = !primed_q[sel] || mag >= 11'(DEADBAND) || snap;
        emit_val = primed_q[sel] ? f : bus.value;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_POTS; k++) begin
                acc[k] <= '0;
                rep[k] <= '0;
            end
            primed_q      <= '0;
            bus.out_valid <= 1'b0;
            bus.out_value <= '0;
            bus.out_index <= '0;
        end else begin
            bus.out_valid <= accept && hit;
            if (accept) begin
                primed_q[sel] <= 1'b1;
                acc[sel]      <= primed_q[sel] ? acc_n[AW-1:0] : AW'(bus.value) << SHIFT;
                if (hit) begin
                    rep[sel]      <= emit_val;
                    bus.out_value <= emit_val;
                    bus.out_index <= sel;
                end
            end
        end
    end
endmodule

// File: tb/tb_pot_smoother.sv
// tb_pot_smoother: directed vectors with hand-computed expectations for pot_smoother.
module tb_pot_smoother;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    pot_smoother_if #(.NUM_POTS(12)) bus ();

    pot_smoother #(.NUM_POTS(12), .SHIFT(2), .DEADBAND(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // drives one sample, returns #1 after the capturing edge
    task automatic step(input logic [9:0] v, input logic [3:0] i, input logic vld);
        @(negedge clk);
        bus.value       = v;
        bus.pot_index   = i;
        bus.value_valid = vld;
        @(posedge clk);
        #1;
        bus.value_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bus.value       = '0;
        bus.pot_index   = '0;
        bus.value_valid = 1'b0;
        do_reset();
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_out_value", 32'(bus.out_value), 0);
        check("rst_out_index", 32'(bus.out_index), 0);
        check("rst_primed", 32'(bus.primed), 0);

        step(10'd512, 4'd3, 1'b1);
        check("prime3_valid", 32'(bus.out_valid), 1);
        check("prime3_index", 32'(bus.out_index), 3);
        check("prime3_value", 32'(bus.out_value), 512);
        check("prime3_primed", 32'(bus.primed), 32'h008);
        step(10'd514, 4'd3, 1'b1);
        check("jitter_valid", 32'(bus.out_valid), 0);
        check("jitter_hold", 32'(bus.out_value), 512);
        check("jitter_acc", 32'(dut.acc[3]), 2050);
        step(10'd1000, 4'd3, 1'b1);
        check("jump1_valid", 32'(bus.out_valid), 1);
        check("jump1_value", 32'(bus.out_value), 634);
        step(10'd1000, 4'd3, 1'b1);
        check("jump2_valid", 32'(bus.out_valid), 1);
        check("jump2_value", 32'(bus.out_value), 726);
        step(10'd0, 4'd0, 1'b0);
        check("idle_valid", 32'(bus.out_valid), 0);

        // filtered value climbs 1020,1021,1022,1022,1022,1022,1023; only the last snaps out
        step(10'd1020, 4'd0, 1'b1);
        check("prime0_value", 32'(bus.out_value), 1020);
        for (int k = 0; k < 6; k++) begin
            step(10'd1023, 4'd0, 1'b1);
            check("snap_quiet", 32'(bus.out_valid), 0);
        end
        step(10'd1023, 4'd0, 1'b1);
        check("snap_valid", 32'(bus.out_valid), 1);
        check("snap_value", 32'(bus.out_value), 1023);
        check("snap_index", 32'(bus.out_index), 0);

        step(10'd77, 4'd13, 1'b1);
        check("oor13_valid", 32'(bus.out_valid), 0);
        step(10'd77, 4'd15, 1'b1);
        check("oor15_valid", 32'(bus.out_valid), 0);
        check("oor_primed", 32'(bus.primed), 32'h009);
        check("oor_hold", 32'(bus.out_value), 1023);

        do_reset();
        step(10'd100, 4'd1, 1'b1);
        check("il_emit1_valid", 32'(bus.out_valid), 1);
        check("il_emit1_value", 32'(bus.out_value), 100);
        step(10'd900, 4'd2, 1'b1);
        check("il_emit2_valid", 32'(bus.out_valid), 1);
        check("il_emit2_value", 32'(bus.out_value), 900);
        check("il_emit2_index", 32'(bus.out_index), 2);
        for (int k = 0; k < 4; k++) begin
            step(10'd100, 4'd1, 1'b1);
            check("il_quiet1", 32'(bus.out_valid), 0);
            step(10'd900, 4'd2, 1'b1);
            check("il_quiet2", 32'(bus.out_valid), 0);
        end
        check("il_acc1", 32'(dut.acc[1]), 400);
        check("il_acc2", 32'(dut.acc[2]), 3600);
        check("il_primed", 32'(bus.primed), 32'h006);

        step(10'd50, 4'd5, 1'b1);
        check("mid_prime_valid", 32'(bus.out_valid), 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(bus.out_valid), 0);
        check("mid_rst_primed", 32'(bus.primed), 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(10'd300, 4'd5, 1'b1);
        check("reprime_valid", 32'(bus.out_valid), 1);
        check("reprime_value", 32'(bus.out_value), 300);
        check("reprime_index", 32'(bus.out_index), 5);
        check("reprime_primed", 32'(bus.primed), 32'h020);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
